// File: rtl/hex_value_writer_pkg.sv
// Shared definitions for the hex display writer: blank code, FSM state
// encodings and the largest value a given number of decimal digits can show.
package hex_value_writer_pkg;

  localparam logic [5:0] BLANK_CODE = 6'h3F;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CONV  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

  function automatic longint unsigned max_val(input int unsigned num_digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < num_digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/hex_value_writer_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-add-3 step per
// cycle, VAL_W cycles per conversion.
module bin2bcd_seq
  import hex_value_writer_pkg::*;
#(
  parameter int VAL_W      = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd_out
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no latch is inferred; flops below use non-blocking '<='.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = bin_in;
      bcd_d  = '0;
      cnt_d  = CNT_W'(VAL_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VAL_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: datapath registers carry no reset; start always reloads them
  // before their contents are used.
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  // done marks the final step: bcd_out holds the result from the next cycle.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(1));
  assign bcd_out = bcd_q;

endmodule

// File: rtl/hex_value_writer.sv
// Avalon-MM master that converts a value to BCD and writes each changed
// digit code to its hex display PIO, blanking leading zeros.
module hex_value_writer
  import hex_value_writer_pkg::*;
#(
  parameter int          VAL_W       = 10,
  parameter int          NUM_DIGITS  = 4,
  parameter int          ADDR_W      = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 16,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VAL_W-1:0]  value_in,
  input  logic              value_valid,
  output logic              value_ready,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned  MAX_VAL  = max_val(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [5:0]              shadow_q [NUM_DIGITS];
  logic [5:0]              shadow_d [NUM_DIGITS];
  logic [5:0]              codes    [NUM_DIGITS];
  logic [5:0]              cur_code;
  logic                    changed;
  logic                    zero_above;
  logic                    accept;
  logic [VAL_W-1:0]        value_sat;
  logic                    conv_start, conv_busy, conv_done;
  logic [NUM_DIGITS*4-1:0] bcd;

  bin2bcd_seq #(
    .VAL_W     (VAL_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bin_in (value_sat),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd_out(bcd)
  );

  assign value_ready = (state_q == IDLE) && !conv_busy;
  assign accept      = value_valid && value_ready;
  assign value_sat   = (64'(value_in) > MAX_VAL) ? VAL_W'(MAX_VAL) : value_in;

  // Scan from the most significant digit so each digit knows whether
  // everything above it is zero; digit 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (BLANK_LZ && (i != 0) && zero_above && (bcd[4*i +: 4] == 4'd0))
        codes[i] = BLANK_CODE;
      else
        codes[i] = {2'b00, bcd[4*i +: 4]};
      zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
    end
  end

  assign cur_code = codes[idx_q];
  assign changed  = (cur_code != shadow_q[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          conv_start = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!changed || !avm_waitrequest) begin
          if (changed) shadow_d[idx_q] = cur_code;
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from held state, so they stay stable under stall.
  assign done          = (state_q == DONE);
  assign avm_write     = (state_q == WRITE) && changed;
  assign avm_address   = avm_write ? ADDR_W'(BASE_ADDR + ADDR_STRIDE * 32'(idx_q)) : '0;
  assign avm_writedata = avm_write ? {26'b0, cur_code} : 32'b0;

  // NOTE: the shadow array is reset on purpose; it must mirror the PIOs,
  // which reset to the blank code on the same system reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= BLANK_CODE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_hex_value_writer.sv
// Scoreboard bench for hex_value_writer: a default 4-digit instance (a_*) and
// a 3-digit instance without leading-zero blanking (b_*).
module tb_hex_value_writer;

  localparam int VAL_W = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [VAL_W-1:0] a_value, b_value;
  logic             a_valid, a_ready, a_done, a_write, a_wait;
  logic             b_valid, b_ready, b_done, b_write, b_wait;
  logic [15:0]      a_addr, b_addr;
  logic [31:0]      a_wdata, b_wdata;

  hex_value_writer u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .value_in       (a_value),
    .value_valid    (a_valid),
    .value_ready    (a_ready),
    .done           (a_done),
    .avm_address    (a_addr),
    .avm_write      (a_write),
    .avm_writedata  (a_wdata),
    .avm_waitrequest(a_wait)
  );

  hex_value_writer #(.NUM_DIGITS(3), .BLANK_LZ(1'b0)) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .value_in       (b_value),
    .value_valid    (b_valid),
    .value_ready    (b_ready),
    .done           (b_done),
    .avm_address    (b_addr),
    .avm_write      (b_write),
    .avm_writedata  (b_wdata),
    .avm_waitrequest(b_wait)
  );

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int unsigned sh_a[4];
  int unsigned sh_b[3];

  int tests = 0;
  int fails = 0;
  int a_wr_cycles = 0;
  int a_done_cnt  = 0;
  int wait_mode   = 0;  // 0: never stall, 1: random stall, 2: stall digit-1 write
  int stall_left  = 0;
  int hold_cycles = 0;
  int hold_bad    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by division, saturate, blank leading
  // zeros, and queue a write for every code that differs from the PIO.
  task automatic predict(input bit b, input int unsigned value);
    int unsigned nd, lim, v, p10, code;
    bit          blank;
    nd    = b ? 3 : 4;
    blank = !b;
    lim   = 1;
    for (int i = 0; i < int'(nd); i++) lim = lim * 10;
    v   = (value > lim - 1) ? lim - 1 : value;
    p10 = 1;
    for (int i = 0; i < int'(nd); i++) begin
      code = (blank && i != 0 && v < p10) ? 32'd63 : (v / p10) % 10;
      if (b) begin
        if (code != sh_b[i]) begin
          exp_b.push_back('{addr: 16 * i, data: code});
          sh_b[i] = code;
        end
      end else begin
        if (code != sh_a[i]) begin
          exp_a.push_back('{addr: 16 * i, data: code});
          sh_a[i] = code;
        end
      end
      p10 = p10 * 10;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) sh_a[i] = 63;
    for (int i = 0; i < 3; i++) sh_b[i] = 63;
    exp_a.delete();
    exp_b.delete();
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_ready : a_ready;
  endfunction

  function automatic logic dn(input bit b);
    return b ? b_done : a_done;
  endfunction

  function automatic int outstanding(input bit b);
    return b ? exp_b.size() : exp_a.size();
  endfunction

  task automatic set_in(input bit b, input logic v, input logic [VAL_W-1:0] val);
    if (b) begin b_valid = v; b_value = val; end
    else   begin a_valid = v; a_value = val; end
  endtask

  // Sends one value and waits (bounded) for done; optionally checks latency
  // and pulses value_valid at cycle pulse_at while the block is busy.
  task automatic send(input bit b, input int unsigned val, input int extra,
                      input bit chk_lat, input int pulse_at);
    int n;
    bit seen;
    @(negedge clk);
    check(b ? "b_ready_idle" : "a_ready_idle", rdy(b), 1'b1);
    set_in(b, 1'b1, VAL_W'(val));
    predict(b, val);
    n    = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) set_in(b, 1'b0, VAL_W'(val));
      if (pulse_at > 1 && n == pulse_at) begin
        set_in(b, 1'b1, 10'd999);
        check("ready_low_busy", rdy(b), 1'b0);
      end else if (pulse_at > 1 && n == pulse_at + 1) begin
        set_in(b, 1'b0, 10'd999);
      end
      if (dn(b)) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: value %0d got no done within 300 cycles", val);
    end else if (chk_lat) begin
      check(b ? "b_latency" : "a_latency", 64'(n), 64'(VAL_W + (b ? 3 : 4) + 1 + extra));
    end
    check(b ? "b_writes_outstanding" : "a_writes_outstanding", 64'(outstanding(b)), 64'd0);
    @(negedge clk);
    check(b ? "b_ready_after_done" : "a_ready_after_done", rdy(b), 1'b1);
    check(b ? "b_done_one_cycle" : "a_done_one_cycle", dn(b), 1'b0);
  endtask

  // Waitrequest generator for instance a.
  always begin
    @(negedge clk);
    case (wait_mode)
      1: a_wait = ($urandom_range(0, 2) == 0);
      2: begin
        if (a_write && a_addr == 16'h10) begin
          hold_cycles++;
          if (a_wdata != 32'd5) hold_bad++;
        end
        if (a_write && a_addr == 16'h10 && stall_left > 0) begin
          a_wait = 1'b1;
          stall_left--;
        end else begin
          a_wait = 1'b0;
        end
      end
      default: a_wait = 1'b0;
    endcase
  end

  // Monitors: a write completes on the next edge when write && !waitrequest.
  always begin
    wr_t e;
    @(negedge clk);
    #1;
    if (a_write) a_wr_cycles++;
    if (a_done) a_done_cnt++;
    if (a_write && !a_wait) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_write: addr 0x%0h data 0x%0h, none expected", a_addr, a_wdata);
      end else begin
        e = exp_a.pop_front();
        check("a_write_addr", 64'(a_addr), 64'(e.addr));
        check("a_write_data", 64'(a_wdata), 64'(e.data));
      end
    end
  end

  always begin
    wr_t e;
    @(negedge clk);
    #1;
    if (b_write && !b_wait) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_write: addr 0x%0h data 0x%0h, none expected", b_addr, b_wdata);
      end else begin
        e = exp_b.pop_front();
        check("b_write_addr", 64'(b_addr), 64'(e.addr));
        check("b_write_data", 64'(b_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v, prev;
    int          done_before;
    reset   = 1'b1;
    a_valid = 1'b0; a_value = '0; a_wait = 1'b0;
    b_valid = 1'b0; b_value = '0; b_wait = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_ready",   a_ready, 1'b1);
    check("rst_done",    a_done,  1'b0);
    check("rst_write",   a_write, 1'b0);
    check("rst_address", 64'(a_addr),  64'd0);
    check("rst_wdata",   64'(a_wdata), 64'd0);
    check("rst_b_ready", b_ready, 1'b1);
    reset = 1'b0;

    // First update writes only non-blank digits.
    a_wr_cycles = 0;
    send(0, 123, 0, 1, 0);
    check("a_123_write_cycles", 64'(a_wr_cycles), 64'd3);
    a_wr_cycles = 0;
    send(0, 123, 0, 1, 0);
    check("a_repeat_write_cycles", 64'(a_wr_cycles), 64'd0);
    send(0, 0, 0, 1, 0);

    // Stall the digit-1 write for three cycles and poke value_valid mid-run.
    wait_mode   = 2;
    stall_left  = 3;
    hold_cycles = 0;
    hold_bad    = 0;
    send(0, 456, 3, 1, 8);
    check("a_stall_hold_cycles", 64'(hold_cycles), 64'd4);
    check("a_stall_hold_data",   64'(hold_bad),    64'd0);

    // Random values against random waitrequest.
    wait_mode = 1;
    prev      = 456;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) v = prev;
      else                           v = $urandom_range(0, 1023);
      send(0, v, 0, 0, 0);
      prev = v;
    end
    wait_mode = 0;

    // Reset during cycle 5 of conversion.
    @(negedge clk);
    set_in(0, 1'b1, 10'd123);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) set_in(0, 1'b0, 10'd123);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    check("midrst_ready", a_ready, 1'b1);
    check("midrst_write", a_write, 1'b0);
    check("midrst_done",  a_done,  1'b0);
    done_before = a_done_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_done", 64'(a_done_cnt), 64'(done_before));
    a_wr_cycles = 0;
    send(0, 45, 0, 1, 0);
    check("a_45_write_cycles", 64'(a_wr_cycles), 64'd2);

    // Three digits, no blanking, saturation above 999.
    send(1, 7, 0, 1, 0);
    send(1, 1000, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      v = $urandom_range(0, 1023);
      send(1, v, 0, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
